// File: rtl/dice_pkg.sv
// Shared types for the dice roll controller: FSM state encoding and stats width.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_SLOW = 2'd2,
        ST_DONE = 2'd3
    } dice_state_e;

    localparam int ROLL_TOTAL_W = 16;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for the raw dice button.
// rise/fall strobe during the cycle before btn_db changes, so they line up with the toggle edge.
module button_debouncer
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Any cycle of agreement restarts the stability window.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign btn_db = db_q;
    assign rise   = db_d & ~db_q;
    assign fall   = ~db_d & db_q;

endmodule

// File: rtl/dice_roll_controller.sv
// Turns a bouncy button into paced roll pulses: fixed-rate spin while held, a
// doubling-interval slow-down tail after release, then a result_valid strobe.
// Optional roll_total statistics counter enabled by defining DICE_ROLL_STATS_EN.
module dice_roll_controller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SPIN_DIV        = 4,
    parameter int SLOW_STEPS      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic roll,
    output logic rolling,
    output logic result_valid,
    output logic btn_db
`ifdef DICE_ROLL_STATS_EN
   ,output logic [ROLL_TOTAL_W-1:0] roll_total
`endif
);

    // ivl must hold the longest slow interval minus one without wrapping.
    localparam int IVL_W  = $clog2(SPIN_DIV << SLOW_STEPS);
    localparam int STEP_W = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS + 1) : 1;

    localparam logic [IVL_W-1:0]  SPIN_END  = IVL_W'(SPIN_DIV - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SLOW_STEPS - 1);

    logic db_rise, db_fall;

    dice_state_e       state_q, state_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IVL_W-1:0]  slow_end;
    logic              roll_q, roll_d;
    logic              rv_q, rv_d;
    logic              rolling_q, rolling_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .btn_db (btn_db),
        .rise   (db_rise),
        .fall   (db_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ivl_q     <= '0;
            step_q    <= '0;
            roll_q    <= 1'b0;
            rv_q      <= 1'b0;
            rolling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ivl_q     <= ivl_d;
            step_q    <= step_d;
            roll_q    <= roll_d;
            rv_q      <= rv_d;
            rolling_q <= rolling_d;
        end
    end

    // Slow interval doubles each step: SPIN_DIV << (step+1) cycles.
    assign slow_end = IVL_W'((SPIN_DIV << (32'(step_q) + 1)) - 1);

    always_comb begin
        state_d   = state_q;
        ivl_d     = ivl_q + 1'b1;
        step_d    = step_q;
        roll_d    = 1'b0;
        rv_d      = 1'b0;
        rolling_d = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                ivl_d  = '0;
                step_d = '0;
                if (db_rise) begin
                    state_d = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (ivl_q == SPIN_END) begin
                    roll_d = 1'b1;
                    ivl_d  = '0;
                end
                // A pulse due on the release edge still goes out; a partial interval is dropped.
                if (db_fall) begin
                    state_d = ST_SLOW;
                    ivl_d   = '0;
                    step_d  = '0;
                end
            end
            ST_SLOW: begin
                if (ivl_q == slow_end) begin
                    roll_d = 1'b1;
                    ivl_d  = '0;
                    step_d = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                rv_d    = 1'b1;
                ivl_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ivl_d   = '0;
            end
        endcase
    end

    assign roll         = roll_q;
    assign result_valid = rv_q;
    assign rolling      = rolling_q;

`ifdef DICE_ROLL_STATS_EN
    logic [ROLL_TOTAL_W-1:0] roll_total_q, roll_total_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            roll_total_q <= '0;
        end else begin
            roll_total_q <= roll_total_d;
        end
    end

    // Saturating count of completed rolls.
    always_comb begin
        roll_total_d = roll_total_q;
        if (rv_d && (roll_total_q != '1)) begin
            roll_total_d = roll_total_q + 1'b1;
        end
    end

    assign roll_total = roll_total_q;
`endif

endmodule

// File: tb/tb_dice_roll_controller.sv
// Randomized bench for dice_roll_controller against a timestamp-based reference model.
module tb_dice_roll_controller;

    localparam int DB = 4;
    localparam int SD = 2;
    localparam int SS = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic roll, rolling, result_valid, btn_db;
`ifdef DICE_ROLL_STATS_EN
    logic [15:0] roll_total;
`endif

    always #5 clk = ~clk;

    dice_roll_controller #(
        .DEBOUNCE_CYCLES (DB),
        .SPIN_DIV        (SD),
        .SLOW_STEPS      (SS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .roll         (roll),
        .rolling      (rolling),
        .result_valid (result_valid),
        .btn_db       (btn_db)
`ifdef DICE_ROLL_STATS_EN
       ,.roll_total   (roll_total)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: sync pipe, stable-run count, and press/release timestamps.
    bit m_s1, m_sync, m_db;
    int m_run;
    int phase;     // 0 idle, 1 spinning, 2 slowing/finished
    int t0, tf, lastp;
    bit exp_roll, exp_res, exp_rolling;

    // Observation log.
    int q_roll[$];
    int first_rise, first_fall, res_cyc, rollfall_cyc;
    bit seen_active, prev_rolling, prev_db;

    function automatic bit slow_pulse(input int off);
        for (int k = 1; k <= SS; k++)
            if (off == SD * ((1 << (k + 1)) - 2)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit b, input bit r);
        bit rise, fall, idle_pre;
        exp_roll = 0; exp_res = 0; exp_rolling = 0;
        if (r) begin
            m_s1 = 0; m_sync = 0; m_db = 0; m_run = 0; phase = 0;
            return;
        end
        case (phase)
            1: begin
                exp_rolling = 1;
                exp_roll    = ((cyc - t0) % SD) == 0;
            end
            2: begin
                exp_roll    = slow_pulse(cyc - tf);
                exp_res     = (cyc == lastp + 1);
                exp_rolling = (cyc <= lastp + 1);
            end
            default: ;
        endcase
        rise = 0; fall = 0;
        if (m_sync != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db  = !m_db;
                m_run = 0;
                rise  = m_db;
                fall  = !m_db;
            end
        end else begin
            m_run = 0;
        end
        m_sync = m_s1;
        m_s1   = b;
        idle_pre = (phase == 0) || (phase == 2 && cyc >= lastp + 2);
        if (idle_pre && rise) begin
            phase = 1; t0 = cyc;
        end else if (phase == 1 && fall) begin
            phase = 2; tf = cyc;
            lastp = tf + SD * ((1 << (SS + 1)) - 2);
        end
    endtask

    // One clock: drive, advance the model, compare every output at edge+1.
    task automatic tick(input bit b, input bit r);
        btn = b; reset = r;
        @(posedge clk);
        cyc++;
        model_step(b, r);
        #1;
        n_vec++;
        if (roll !== exp_roll) begin
            n_err++; $display("FAIL roll cyc=%0d got=%b exp=%b", cyc, roll, exp_roll);
        end
        n_vec++;
        if (result_valid !== exp_res) begin
            n_err++; $display("FAIL result_valid cyc=%0d got=%b exp=%b", cyc, result_valid, exp_res);
        end
        n_vec++;
        if (rolling !== exp_rolling) begin
            n_err++; $display("FAIL rolling cyc=%0d got=%b exp=%b", cyc, rolling, exp_rolling);
        end
        n_vec++;
        if (btn_db !== m_db) begin
            n_err++; $display("FAIL btn_db cyc=%0d got=%b exp=%b", cyc, btn_db, m_db);
        end
        n_vec++;
        if ((roll & result_valid) !== 1'b0) begin
            n_err++; $display("FAIL roll_rv_overlap cyc=%0d got=1 exp=0", cyc);
        end
        if (roll === 1'b1) q_roll.push_back(cyc);
        if (result_valid === 1'b1) res_cyc = cyc;
        if (prev_rolling && rolling === 1'b0) rollfall_cyc = cyc;
        if (!prev_db && btn_db === 1'b1 && first_rise < 0) first_rise = cyc;
        if (prev_db && btn_db === 1'b0 && first_fall < 0) first_fall = cyc;
        if (btn_db === 1'b1 || rolling === 1'b1 || result_valid === 1'b1) seen_active = 1;
        prev_rolling = (rolling === 1'b1);
        prev_db      = (btn_db === 1'b1);
    endtask

    task automatic clear_log();
        q_roll.delete();
        first_rise = -1; first_fall = -1; res_cyc = -1; rollfall_cyc = -1;
        seen_active = 0;
    endtask

    task automatic check_slow_tail(input string tag);
        int offs[$];
        foreach (q_roll[i]) if (q_roll[i] > first_fall) offs.push_back(q_roll[i] - first_fall);
        n_vec++;
        if (offs.size() != SS) begin
            n_err++; $display("FAIL %s_pulse_count got=%0d exp=%0d", tag, offs.size(), SS);
        end else begin
            for (int k = 1; k <= SS; k++) begin
                n_vec++;
                if (offs[k-1] != SD * ((1 << (k + 1)) - 2)) begin
                    n_err++;
                    $display("FAIL %s_pulse%0d_offset got=%0d exp=%0d", tag, k, offs[k-1], SD * ((1 << (k + 1)) - 2));
                end
            end
        end
        n_vec++;
        if (res_cyc - first_fall != SD * ((1 << (SS + 1)) - 2) + 1) begin
            n_err++; $display("FAIL %s_result_offset got=%0d exp=%0d", tag, res_cyc - first_fall, SD * ((1 << (SS + 1)) - 2) + 1);
        end
        n_vec++;
        if (rollfall_cyc - first_fall != SD * ((1 << (SS + 1)) - 2) + 2) begin
            n_err++; $display("FAIL %s_rolling_low_offset got=%0d exp=%0d", tag, rollfall_cyc - first_fall, SD * ((1 << (SS + 1)) - 2) + 2);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        n_vec++;
        if ({roll, rolling, result_valid, btn_db} !== 4'b0) begin
            n_err++; $display("FAIL reset_outputs got=%b exp=0000", {roll, rolling, result_valid, btn_db});
        end
        for (int i = 0; i < DB + 4; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        clear_log();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        n_vec++;
        if (seen_active !== 1'b0 || q_roll.size() != 0) begin
            n_err++; $display("FAIL glitch_activity got=%b/%0d exp=0/0", seen_active, q_roll.size());
        end
    endtask

    task automatic test_hold();
        int start, n, first, prevr, bad;
        clear_log();
        start = cyc;
        for (int i = 0; i < 2 + DB; i++) tick(1'b1, 1'b0);
        n_vec++;
        if (first_rise != start + 2 + DB) begin
            n_err++; $display("FAIL press_latency got=%0d exp=%0d", first_rise - start, 2 + DB);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        n = 0; first = -1; prevr = 0; bad = 0;
        foreach (q_roll[i]) if (q_roll[i] > first_rise) begin
            if (first < 0) first = q_roll[i];
            else if (q_roll[i] - prevr != SD) bad++;
            prevr = q_roll[i];
            n++;
        end
        n_vec++;
        if (n != 20 / SD) begin
            n_err++; $display("FAIL hold_pulse_count got=%0d exp=%0d", n, 20 / SD);
        end
        n_vec++;
        if (first - first_rise != SD) begin
            n_err++; $display("FAIL hold_first_pulse got=%0d exp=%0d", first - first_rise, SD);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL hold_spacing got=%0d bad gaps exp=0", bad);
        end
    endtask

    task automatic test_release();
        int start;
        clear_log();
        start = cyc;
        for (int i = 0; i < DB + 2 + 40; i++) tick(1'b0, 1'b0);
        n_vec++;
        if (first_fall != start + 2 + DB) begin
            n_err++; $display("FAIL release_latency got=%0d exp=%0d", first_fall - start, 2 + DB);
        end
        check_slow_tail("release");
    endtask

    task automatic test_bounce();
        int late;
        for (int i = 0; i < DB + 2 + 7; i++) tick(1'b1, 1'b0);
        clear_log();
        for (int i = 0; i < DB + 2; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        check_slow_tail("bounce");
        late = 0;
        foreach (q_roll[i]) if (q_roll[i] > res_cyc) late++;
        n_vec++;
        if (btn_db !== 1'b1 || rolling !== 1'b0 || late != 0) begin
            n_err++; $display("FAIL bounce_idle_after_done got=db%b/rolling%b/late%0d exp=db1/rolling0/late0", btn_db, rolling, late);
        end
        for (int i = 0; i < DB + 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < DB + 4; i++) tick(1'b1, 1'b0);
        n_vec++;
        if (rolling !== 1'b1) begin
            n_err++; $display("FAIL repress_spin got=%b exp=1", rolling);
        end
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_spin();
        for (int i = 0; i < DB + 2 + 5; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        n_vec++;
        if ({roll, rolling, result_valid, btn_db} !== 4'b0) begin
            n_err++; $display("FAIL midspin_reset got=%b exp=0000", {roll, rolling, result_valid, btn_db});
        end
        clear_log();
        for (int i = 0; i < DB + 2; i++) tick(1'b1, 1'b0);
        n_vec++;
        if (q_roll.size() != 0) begin
            n_err++; $display("FAIL midspin_no_roll got=%0d exp=0", q_roll.size());
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        n_vec++;
        if (rolling !== 1'b1) begin
            n_err++; $display("FAIL midspin_respin got=%b exp=1", rolling);
        end
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit b;
        int len;
        for (int s = 0; s < 60; s++) begin
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            for (int i = 0; i < len; i++) tick(b, ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b0);
    endtask

`ifdef DICE_ROLL_STATS_EN
    task automatic test_stats();
        tick(1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DB + 6; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 45; i++) tick(1'b0, 1'b0);
        end
        n_vec++;
        if (roll_total !== 16'd3) begin
            n_err++; $display("FAIL stats_count got=%0d exp=3", roll_total);
        end
        force dut.roll_total_q = 16'hFFFF;
        tick(1'b0, 1'b0);
        release dut.roll_total_q;
        for (int i = 0; i < DB + 6; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 45; i++) tick(1'b0, 1'b0);
        n_vec++;
        if (roll_total !== 16'hFFFF) begin
            n_err++; $display("FAIL stats_saturate got=%h exp=ffff", roll_total);
        end
    endtask
`endif

    initial begin
        btn = 1'b0; reset = 1'b1;
        m_s1 = 0; m_sync = 0; m_db = 0; m_run = 0; phase = 0;
        t0 = 0; tf = 0; lastp = -100;
        prev_rolling = 0; prev_db = 0;
        clear_log();
        test_reset();
        test_glitch();
        test_hold();
        test_release();
        test_bounce();
        test_reset_mid_spin();
        test_random();
`ifdef DICE_ROLL_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
